// File: rtl/mseq_pkg.sv
// Shared encodings for the control-unit microsequencer.
// Optional watchdog is enabled by defining MSEQ_WATCHDOG_EN.
package mseq_pkg;

    localparam int STATE_W = 7;

    localparam logic [2:0] NS_ENC       = 3'b000;
    localparam logic [2:0] NS_FETCH     = 3'b001;
    localparam logic [2:0] NS_TGT       = 3'b010;
    localparam logic [2:0] NS_INC       = 3'b011;
    localparam logic [2:0] NS_STS_ENC   = 3'b100;
    localparam logic [2:0] NS_STS_FETCH = 3'b101;
    localparam logic [2:0] NS_STS_INC   = 3'b110;
    localparam logic [2:0] NS_HOLD      = 3'b111;

    localparam logic [1:0] CS_MOC  = 2'b00;
    localparam logic [1:0] CS_COND = 2'b01;
    localparam logic [1:0] CS_DMOC = 2'b10;
    localparam logic [1:0] CS_ZERO = 2'b11;

    localparam logic [1:0] M_ENC   = 2'b00;
    localparam logic [1:0] M_FETCH = 2'b01;
    localparam logic [1:0] M_TGT   = 2'b10;
    localparam logic [1:0] M_INC   = 2'b11;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } mseq_fsm_e;

    // Conditional modes that can spin on a memory handshake
    function automatic logic is_cond_mode(input logic [2:0] n);
        return (n == NS_STS_ENC) || (n == NS_STS_FETCH) ||
               (n == NS_STS_INC);
    endfunction

endpackage

// File: rtl/mseq_next_addr.sv
// Next-address mode decoder: maps n_sel and the branch status
// to a 2-bit source select plus a hold flag.
module mseq_next_addr
    import mseq_pkg::*;
(
    input  logic [2:0] n_sel,
    input  logic       sts,
    output logic [1:0] m_sel,
    output logic       hold
);

    // Pick the address source for the current microinstruction
    always_comb begin
        m_sel = M_ENC;
        hold  = 1'b0;
        unique case (n_sel)
            NS_ENC:       m_sel = M_ENC;
            NS_FETCH:     m_sel = M_FETCH;
            NS_TGT:       m_sel = M_TGT;
            NS_INC:       m_sel = M_INC;
            NS_STS_ENC:   m_sel = sts ? M_ENC   : M_TGT;
            NS_STS_FETCH: m_sel = sts ? M_FETCH : M_TGT;
            NS_STS_INC:   m_sel = sts ? M_INC   : M_FETCH;
            NS_HOLD:      hold  = 1'b1;
            default:      hold  = 1'b1;
        endcase
    end

endmodule

// File: rtl/microsequencer_ctrl.sv
// Registered microsequencer with handshake wait detection.
// Define MSEQ_WATCHDOG_EN to add the wait-loop abort watchdog.
module microsequencer_ctrl
#(
    parameter logic [mseq_pkg::STATE_W-1:0] RESET_STATE = 7'd0,
    parameter logic [mseq_pkg::STATE_W-1:0] FETCH_STATE = 7'd1
`ifdef MSEQ_WATCHDOG_EN
    ,
    parameter int                           TIMEOUT     = 15,
    parameter logic [mseq_pkg::STATE_W-1:0] ABORT_STATE = 7'd127
`endif
)
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [2:0]                   n_sel,
    input  logic [1:0]                   s_sel,
    input  logic                         inv,
    input  logic                         moc,
    input  logic                         cond,
    input  logic                         dmoc,
    input  logic [mseq_pkg::STATE_W-1:0] encoder_state,
    input  logic [mseq_pkg::STATE_W-1:0] cr_target,
    output logic [mseq_pkg::STATE_W-1:0] state,
    output logic                         mem_wait,
    output logic                         timeout
);

    import mseq_pkg::*;

    logic               cond_sel;
    logic               sts;
    logic [1:0]         m_sel;
    logic               hold;
    logic [STATE_W-1:0] next_state;
    logic               wait_loop;
    mseq_fsm_e          fsm;

`ifdef MSEQ_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign timeout = 1'b0;
`endif

    // Branch condition select
    always_comb begin
        cond_sel = 1'b0;
        unique case (s_sel)
            CS_MOC:  cond_sel = moc;
            CS_COND: cond_sel = cond;
            CS_DMOC: cond_sel = dmoc;
            CS_ZERO: cond_sel = 1'b0;
            default: cond_sel = 1'b0;
        endcase
    end

    assign sts = cond_sel ^ inv;

    mseq_next_addr u_next_addr (
        .n_sel (n_sel),
        .sts   (sts),
        .m_sel (m_sel),
        .hold  (hold)
    );

    // Next-state source mux
    always_comb begin
        next_state = state;
        if (!hold) begin
            unique case (m_sel)
                M_ENC:   next_state = encoder_state;
                M_FETCH: next_state = FETCH_STATE;
                M_TGT:   next_state = cr_target;
                M_INC:   next_state = state + STATE_W'(1);
                default: next_state = state;
            endcase
        end
    end

    assign wait_loop = is_cond_mode(n_sel) &&
                       ((s_sel == CS_MOC) || (s_sel == CS_DMOC)) &&
                       (next_state == state);

    // State register, wait FSM and watchdog
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RESET_STATE;
            fsm      <= RUN;
            mem_wait <= 1'b0;
`ifdef MSEQ_WATCHDOG_EN
            timeout  <= 1'b0;
            wait_cnt <= '0;
`endif
        end else if (en) begin
            state <= next_state;
`ifdef MSEQ_WATCHDOG_EN
            timeout <= 1'b0;
`endif
            unique case (fsm)
                RUN: begin
                    if (wait_loop) begin
                        fsm      <= WAIT;
                        mem_wait <= 1'b1;
`ifdef MSEQ_WATCHDOG_EN
                        wait_cnt <= CNT_W'(1);
`endif
                    end
                end
                WAIT: begin
                    if (!wait_loop) begin
                        fsm      <= RUN;
                        mem_wait <= 1'b0;
`ifdef MSEQ_WATCHDOG_EN
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_LAST) begin
                        fsm      <= ABORT;
                        mem_wait <= 1'b0;
                        state    <= ABORT_STATE;
                        timeout  <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
`endif
                    end
                end
                default: begin
                    fsm      <= RUN;
                    mem_wait <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_microsequencer_ctrl.sv
// Directed vector bench for microsequencer_ctrl.
// Watchdog sequences are checked when MSEQ_WATCHDOG_EN is defined.
module tb_microsequencer_ctrl;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [2:0] n_sel;
    logic [1:0] s_sel;
    logic       inv, moc, cond, dmoc;
    logic [6:0] encoder_state, cr_target;
    logic [6:0] state;
    logic       mem_wait, timeout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic       en;
        logic [2:0] n;
        logic [1:0] s;
        logic       inv;
        logic       moc;
        logic       cond;
        logic       dmoc;
        logic [6:0] enc;
        logic [6:0] tgt;
        logic [6:0] exp_st;
        logic       exp_mw;
    } vec_t;

    vec_t vecs[$];

    microsequencer_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .n_sel         (n_sel),
        .s_sel         (s_sel),
        .inv           (inv),
        .moc           (moc),
        .cond          (cond),
        .dmoc          (dmoc),
        .encoder_state (encoder_state),
        .cr_target     (cr_target),
        .state         (state),
        .mem_wait      (mem_wait),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(
        input string nm, input logic e, input logic [2:0] n,
        input logic [1:0] s, input logic i, input logic m,
        input logic c, input logic d, input logic [6:0] enc,
        input logic [6:0] tgt, input logic [6:0] st,
        input logic mw);
        vec_t x;
        x.name = nm; x.en = e; x.n = n; x.s = s; x.inv = i;
        x.moc = m; x.cond = c; x.dmoc = d; x.enc = enc;
        x.tgt = tgt; x.exp_st = st; x.exp_mw = mw;
        return x;
    endfunction

    task automatic set_in(input vec_t x);
        en = x.en; n_sel = x.n; s_sel = x.s; inv = x.inv;
        moc = x.moc; cond = x.cond; dmoc = x.dmoc;
        encoder_state = x.enc; cr_target = x.tgt;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Apply one vector for one edge and check at the next negedge
    task automatic step(input vec_t x);
        set_in(x);
        @(negedge clk);
        chk({x.name, " state"}, int'(state), int'(x.exp_st));
        chk({x.name, " mem_wait"}, int'(mem_wait), int'(x.exp_mw));
        chk({x.name, " timeout"}, int'(timeout), 0);
    endtask

    task automatic load(input logic [6:0] t);
        step(v("load", 1, 3'b010, 2'b11, 0, 0, 0, 0, 0, t, t, 0));
    endtask

    initial begin
        vec_t w;
        // main vector table
        vecs.push_back(v("ld5",     1, 3'b010, 2'b11, 0, 0, 0, 0,  0,   5,   5, 0));
        vecs.push_back(v("inc6",    1, 3'b011, 2'b11, 0, 0, 0, 0,  0,   0,   6, 0));
        vecs.push_back(v("inc7",    1, 3'b011, 2'b11, 0, 0, 0, 0,  0,   0,   7, 0));
        vecs.push_back(v("inc8",    1, 3'b011, 2'b11, 0, 0, 0, 0,  0,   0,   8, 0));
        vecs.push_back(v("ld127",   1, 3'b010, 2'b11, 0, 0, 0, 0,  0, 127, 127, 0));
        vecs.push_back(v("wrap",    1, 3'b011, 2'b11, 0, 0, 0, 0,  0,   0,   0, 0));
        vecs.push_back(v("enc",     1, 3'b000, 2'b11, 0, 0, 0, 0, 33,   0,  33, 0));
        vecs.push_back(v("fetch",   1, 3'b001, 2'b11, 0, 0, 0, 0,  0,   0,   1, 0));
        vecs.push_back(v("hold",    1, 3'b111, 2'b00, 0, 0, 0, 0, 90,  91,   1, 0));
        vecs.push_back(v("ld40",    1, 3'b010, 2'b11, 0, 0, 0, 0,  0,  40,  40, 0));
        vecs.push_back(v("inv1",    1, 3'b110, 2'b01, 1, 0, 1, 0,  0,   0,   1, 0));
        vecs.push_back(v("ld40b",   1, 3'b010, 2'b11, 0, 0, 0, 0,  0,  40,  40, 0));
        vecs.push_back(v("inv0",    1, 3'b110, 2'b01, 0, 0, 1, 0,  0,   0,  41, 0));
        vecs.push_back(v("zero_t",  1, 3'b100, 2'b11, 0, 1, 1, 1, 60,  50,  50, 0));
        vecs.push_back(v("zero_e",  1, 3'b100, 2'b11, 1, 0, 0, 0, 60,  50,  60, 0));
        vecs.push_back(v("c101_t",  1, 3'b101, 2'b01, 0, 0, 0, 0,  0,  70,  70, 0));
        vecs.push_back(v("c101_f",  1, 3'b101, 2'b01, 0, 0, 1, 0,  0,  70,   1, 0));
        vecs.push_back(v("stall",   0, 3'b011, 2'b11, 0, 0, 0, 0,  0,   0,   1, 0));
        vecs.push_back(v("ld20",    1, 3'b010, 2'b11, 0, 0, 0, 0,  0,  20,  20, 0));
        vecs.push_back(v("dmoc_w1", 1, 3'b100, 2'b10, 0, 0, 0, 0,  9,  20,  20, 1));
        vecs.push_back(v("dmoc_w2", 1, 3'b100, 2'b10, 0, 1, 1, 0,  9,  20,  20, 1));
        vecs.push_back(v("dmoc_ok", 1, 3'b100, 2'b10, 0, 0, 0, 1,  9,  20,   9, 0));
        vecs.push_back(v("inv_w",   1, 3'b100, 2'b00, 1, 1, 0, 0, 15,   9,   9, 1));
        vecs.push_back(v("inv_ok",  1, 3'b100, 2'b00, 1, 0, 0, 0, 15,   9,  15, 0));

        // reset state
        reset = 1'b1;
        set_in(v("idle", 0, 3'b111, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0));
        #12;
        chk("reset state", int'(state), 0);
        chk("reset mem_wait", int'(mem_wait), 0);
        chk("reset timeout", int'(timeout), 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) step(vecs[i]);

        // MOC wait then completion to encoder
        load(20);
        w = v("moc_w", 1, 3'b100, 2'b00, 0, 0, 0, 0, 9, 20, 20, 1);
        step(w);
        step(v("moc_ok", 1, 3'b100, 2'b00, 0, 1, 0, 0, 9, 20, 9, 0));

        // stall during WAIT after seven waiting edges
        load(20);
        for (int i = 0; i < 7; i++) step(w);
        for (int i = 0; i < 5; i++)
            step(v("stall_w", 0, 3'b100, 2'b00, 0, 0, 0, 0, 9, 20, 20, 1));
        for (int i = 0; i < 7; i++) step(w);
`ifdef MSEQ_WATCHDOG_EN
        set_in(w);
        @(negedge clk);
        chk("stall abort state", int'(state), 127);
        chk("stall abort timeout", int'(timeout), 1);
        chk("stall abort mem_wait", int'(mem_wait), 0);
        step(v("post_abort", 1, 3'b011, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0));

        // full watchdog expiry
        load(20);
        for (int i = 0; i < TO - 1; i++) step(w);
        set_in(w);
        @(negedge clk);
        chk("wd state", int'(state), 127);
        chk("wd timeout", int'(timeout), 1);
        step(v("wd_run", 1, 3'b010, 2'b11, 0, 0, 0, 0, 0, 3, 3, 0));

        // completion on the last allowed cycle
        load(20);
        for (int i = 0; i < TO - 1; i++) step(w);
        step(v("late_ok", 1, 3'b100, 2'b00, 0, 1, 0, 0, 9, 20, 9, 0));
`else
        step(w);
        step(w);
        step(v("late_ok", 1, 3'b100, 2'b00, 0, 1, 0, 0, 9, 20, 9, 0));
`endif

        // asynchronous reset in the middle of WAIT
        load(20);
        for (int i = 0; i < 3; i++) step(w);
        #2;
        reset = 1'b1;
        #1;
        chk("mid reset state", int'(state), 0);
        chk("mid reset mem_wait", int'(mem_wait), 0);
        chk("mid reset timeout", int'(timeout), 0);
        @(negedge clk);
        reset = 1'b0;
        step(v("after_rst", 1, 3'b011, 2'b11, 0, 0, 0, 0, 0, 0, 1, 0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
